// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores push bytes into a TX FIFO,
// a serializer drains it onto tx, loads return FIFO status and the divisor.
module uart_tx_mmio #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 1249
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [3:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        irq
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [FIFO_DEPTH-1:0][7:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;
    logic                       ovf;
    logic [15:0]                div;

    state_t                     state;
    logic [7:0]                 shift;
    logic [2:0]                 bit_idx;
    logic [15:0]                baud_cnt, reload;

    logic sel_data, sel_stat, sel_div;
    logic full, empty, busy, push, push_ok, pop, bit_end, irq_nxt;
    logic [7:0]  head;
    logic [31:0] status;
    logic        unused_ok;

    assign sel_data = (addr[3:2] == 2'd0);
    assign sel_stat = (addr[3:2] == 2'd1);
    assign sel_div  = (addr[3:2] == 2'd2);

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign head    = mem[rd_ptr];
    assign bit_end = (baud_cnt == 16'd0);

    // Acceptance and pop both look at the count from before this edge, so a
    // push at full is lost even when the serializer pops on the same edge.
    assign push    = wr_en && sel_data;
    assign push_ok = push && !full;
    assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

    // irq follows the serializer going idle with nothing left to send.
    assign irq_nxt = empty && ((state == IDLE) || (state == STOP && bit_end));

    assign status    = {17'd0, 7'(count), 4'd0, ovf, busy, empty, full};
    assign unused_ok = ^{addr[1:0], wr_data[31:16]};

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (addr[3:2])
                2'd1:    rd_data = status;
                2'd2:    rd_data = {16'd0, div};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) mem[wr_ptr] <= wr_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            div    <= 16'(DEFAULT_DIV);
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full)
                ovf <= 1'b1;
            else if (wr_en && sel_stat && wr_data[3])
                ovf <= 1'b0;
            if (wr_en && sel_div) div <= wr_data[15:0];
        end
    end

    // Serializer: reload is captured at each pop so DIV writes only affect
    // frames that start afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            irq      <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            reload   <= '0;
        end else begin
            irq <= irq_nxt;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shift    <= head;
                        reload   <= div;
                        baud_cnt <= div;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= reload;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= reload;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!empty) begin
                            shift    <= head;
                            reload   <= div;
                            baud_cnt <= div;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: queue/elapsed-time reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_mmio;

    localparam int DEPTH   = 8;
    localparam int DEF_DIV = 1249;

    logic        clk = 1'b0, reset = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        tx, irq;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_on = 1'b0;

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the frame currently on the wire,
    // described by its byte, its divisor and cycles elapsed since the pop.
    logic [7:0]  mq[$];
    bit          m_act = 1'b0;
    int          m_el = 0, m_d = 0;
    logic [7:0]  m_cur = '0;
    logic [15:0] m_div = 16'(DEF_DIV);
    bit          m_ovf = 1'b0, m_irq = 1'b1;

    always @(posedge clk) begin
        int pre;
        cyc++;
        if (!reset) begin
            mq.delete();
            m_act = 1'b0; m_ovf = 1'b0; m_irq = 1'b1;
            m_div = 16'(DEF_DIV);
        end else begin
            pre = mq.size();
            if (m_act) begin
                if (m_el == 10 * (m_d + 1) - 1) m_act = 1'b0;
                else m_el++;
            end
            if (!m_act && pre > 0) begin
                m_cur = mq.pop_front();
                m_d   = int'(m_div);
                m_el  = 0;
                m_act = 1'b1;
            end
            if (wr_en) begin
                case (addr[3:2])
                    2'd0: if (pre == DEPTH) m_ovf = 1'b1; else mq.push_back(wr_data[7:0]);
                    2'd1: if (wr_data[3]) m_ovf = 1'b0;
                    2'd2: m_div = wr_data[15:0];
                    default: ;
                endcase
            end
            m_irq = !m_act && (pre == 0);
        end
    end

    function automatic logic m_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_el / (m_d + 1);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic [31:0] m_rd(input logic en, input logic [3:0] a);
        int n;
        n = mq.size();
        if (!en) return 32'd0;
        case (a[3:2])
            2'd1:    return {17'd0, 7'(n), 4'd0, m_ovf, m_act, (n == 0), (n == DEPTH)};
            2'd2:    return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tx", {31'd0, tx}, {31'd0, m_tx()});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("rd_data", rd_data, m_rd(rd_en, addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        rd_en = 1'b1; addr = a;
        #1;
        d = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) step();
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 3000 && irq !== 1'b1; i++) step();
        chk(nm, {31'd0, irq}, 32'd1);
    endtask

    initial begin
        logic [31:0] d, r;
        int n;
        int a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        bit low_seen;

        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        chk_on = 1'b1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd1);
        rd(4'h8, d); chk("reset_div", d, 32'h0000_04E1);
        rd_en = 1'b0; addr = 4'h8; #1;
        chk("rd_en_low", rd_data, 32'd0);
        rd(4'h4, d); chk("reset_status", d, 32'h2);

        // Single byte 0xA5 at 4 clocks per bit
        wr(4'h8, 32'd3);
        wr(4'h0, 32'hA5);
        n = cyc;
        rd(4'h4, d); chk("push_status", d, 32'h100);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("a5_bit", {31'd0, tx}, 32'(a5[i/4]));
        end
        chk("a5_irq_low", {31'd0, irq}, 32'd0);
        step();
        chk("a5_irq_back", {31'd0, irq}, 32'd1);
        rd(4'h4, d); chk("a5_idle_status", d, 32'h2);

        // Fill and overflow
        for (int i = 1; i <= 9; i++) wr(4'h0, 32'(i));
        rd(4'h4, d); chk("fill_status", d, 32'h805);
        rd(4'h0, d); chk("txdata_read", d, 32'd0);
        rd(4'h4, d); chk("fill_status_after_read", d, 32'h805);
        wr(4'h0, 32'h0A);
        rd(4'h4, d); chk("overflow_status", d, 32'h80D);
        wait_idle("fill_drain");
        wr(4'h4, 32'h8);
        rd(4'h4, d); chk("ovf_clear", d, 32'h2);

        // Push at full on the exact edge STOP ends and pops, DIV=0
        wr(4'h8, 32'd0);
        for (int i = 0; i < 9; i++) wr(4'h0, 32'h10 + 32'(i));
        step(); step();
        wr(4'h0, 32'hEE);
        rd(4'h4, d); chk("simul_pushpop", d, 32'h70C);
        wait_idle("simul_drain");
        wr(4'h4, 32'h8);

        // DIV change mid-frame
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h00);
        n = cyc;
        wr(4'h0, 32'h55);
        wait_cyc(n + 11);
        wr(4'h8, 32'd1);
        wait_cyc(n + 36); chk("div_old_bit7", {31'd0, tx}, 32'd0);
        step();           chk("div_old_stop", {31'd0, tx}, 32'd1);
        wait_cyc(n + 40); chk("div_old_stop_end", {31'd0, tx}, 32'd1);
        step();           chk("div_new_start", {31'd0, tx}, 32'd0);
        step(); step();   chk("div_new_bit0", {31'd0, tx}, 32'd1);
        step(); step();   chk("div_new_bit1", {31'd0, tx}, 32'd0);
        wait_idle("div_drain");

        // Reset mid-frame with 3 bytes queued; DIV write during reset dropped
        wr(4'h8, 32'd3);
        for (int i = 0; i < 4; i++) wr(4'h0, 32'hC0 + 32'(i));
        n = cyc;
        wait_cyc(n + 10);
        reset = 1'b0; wr_en = 1'b1; addr = 4'h8; wr_data = 32'd7;
        step();
        reset = 1'b1; wr_en = 1'b0;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        rd(4'h4, d); chk("rst_status", d, 32'h2);
        rd(4'h8, d); chk("rst_div", d, 32'h0000_04E1);
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        chk("rst_no_frames", {31'd0, low_seen}, 32'd0);
        rd(4'hC, d); chk("reg_c_read", d, 32'd0);

        // Random traffic with small divisors
        wr(4'h8, 32'd2);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom();
            wr_en = ($urandom_range(0, 3) == 0);
            addr  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) addr[3:2] = 2'd0;
            wr_data = (addr[3:2] == 2'd2) ? {r[31:16], 14'd0, r[1:0]} : r;
            rd_en = ($urandom_range(0, 1) == 1);
            step();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        wait_idle("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the RV32I core's data bus, downstream of the load/store path. Stores to its register window push bytes into a transmit FIFO. An 8N1 serializer drains the FIFO onto a single `tx` pin. Loads return FIFO status so firmware can poll before writing.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8. Transmit FIFO entries; must be a power of two, 2–64.
- `DEFAULT_DIV`, default 1249. Reset value of the divisor; bit period = DIV+1 clocks (12 MHz / 9600 baud).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `wr_en`  in  1  store strobe for this window, one cycle per store.
- `rd_en`  in  1  load strobe (qualifies `rd_data`; no side effects).
- `addr`  in  4  byte offset within window; bits [1:0] ignored.
- `wr_data`  in  32  store data.
- `rd_data`  out  32  load data, combinational from `addr` and registered state; 0 when `rd_en`=0.
- `tx`  out  1  serial line, registered, idle high.
- `irq`  out  1  registered; high while FIFO empty and serializer idle.

## Operation
Registers:
- 0x0 TXDATA, write only. Push `wr_data[7:0]`. Reads return 0.
- 0x4 STATUS, read/write.
  - bit0 full; bit1 empty; bit2 busy (FSM not IDLE); bit3 overflow, sticky.
  - bits[14:8] FIFO count.
  - Writing 1 to bit3 clears overflow; other bits are read-only.
- 0x8 DIV. Bits[15:0] hold the divisor; upper bits read 0 and are ignored on write.
- 0xC: reads 0, writes ignored.

FIFO and push rules:
- Push acceptance uses the count at the start of the cycle.
- A push when count == FIFO_DEPTH is dropped and sets overflow, even if a pop happens in the same cycle.
- A push and a pop in the same cycle with 0 < count < DEPTH leaves count unchanged.

Serializer FSM (IDLE, START, DATA, STOP):
- IDLE: if FIFO is non-empty, pop the head into the shift register and latch DIV into the bit counter reload. Go to START. `tx` goes low on that same edge.
- START: hold `tx`=0 for DIV+1 clocks, then go to DATA with bit index 0.
- DATA: drive `shift[0]` for DIV+1 clocks, then shift right and increment the index. After index 7 completes, go to STOP.
- STOP: hold `tx`=1 for DIV+1 clocks. Then, if the FIFO is non-empty, pop and enter START directly with no idle gap; otherwise go to IDLE.
- Bit order is LSB first. A frame is exactly 10·(DIV+1) clocks.

DIV rules:
- A DIV write mid-frame does not affect the current frame; it applies at the next pop.
- DIV=0 means 1 clock per bit and is legal.

## Timing
Reset (`reset`=0 at an edge) sets:
- `tx`=1, `irq`=1
- FIFO empty, count=0, overflow=0
- FSM IDLE
- DIV=DEFAULT_DIV

Reset rules:
- Reset mid-frame aborts the frame immediately; `tx` is high on the next cycle.
- Register writes during reset are ignored.

Latency:
- A push at edge N into an empty FIFO with an idle FSM: count=1 and busy=0 after N. The pop happens at edge N+1, where `tx`=0, count=0 and busy=1.
- STATUS reflects a push or pop on the cycle after the edge that performed it.
- `irq` falls at the edge after the push (N+1) and rises at the edge that ends the STOP of the last frame.

## Test plan
- Single byte, DIV=3: write 0xA5 to 0x0.
  - From the next edge, `tx` reads (4 clocks each) 0,1,0,1,0,0,1,0,1,1.
  - Then `tx` stays idle high; `irq` returns to 1 after 40 clocks.
- Fill and overflow, DIV=3: 9 consecutive writes 0x01..0x09.
  - First byte is popped, so 8 remain. STATUS=full with count=8 and overflow=0.
  - A 10th write while full sets overflow=1 and is lost.
  - Transmitted sequence is 0x01..0x09 with no inter-frame gap.
  - Writing 0x8 to STATUS clears overflow.
- Simultaneous push/pop at full, DIV=0: write while full on the exact cycle STOP ends and pops.
  - The push is dropped, overflow=1, count=FIFO_DEPTH−1.
- DIV change mid-frame: DIV=3, send 0x00, write DIV=1 during DATA.
  - The current frame stays at 4 clocks/bit.
  - The queued next byte uses 2 clocks/bit (20-clock frame).
- Reset mid-frame: assert `reset`=0 for one cycle during DATA with 3 bytes queued.
  - Next cycle: `tx`=1, count=0, busy=0, DIV=1249, overflow=0.
  - No further frames are sent.
- Read side: `rd_en`=1 at 0x8 after reset returns 0x000004E1. `rd_en`=0 returns 0. Reading 0x0 returns 0 and does not pop.
